// File: rtl/serial_parity_gen.sv
// Serial parity accumulator. It sums FRAME_LEN accepted bits (XOR) and publishes the frame parity with a done pulse.
// Optional build macro PARITY_ODD_EN: the published value becomes odd parity; the default is even parity.
module serial_parity_gen #(
    parameter int FRAME_LEN = 8
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       start_in,
    input  logic       abort_in,
    input  logic       bit_in,
    input  logic       bit_valid_in,
    output logic       bit_ready_out,
    output logic       busy_out,
    output logic [8:0] count_out,
    output logic       parity_out,
    output logic       done_out
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    localparam logic [8:0] LAST_CNT = 9'(FRAME_LEN);

    logic [1:0] state_r;
    logic [1:0] state_nxt_s;
    logic       acc_r;
    logic       acc_nxt_s;
    logic [8:0] count_r;
    logic [8:0] count_nxt_s;
    logic       parity_r;
    logic       parity_nxt_s;
    logic       ready_r;
    logic       busy_r;
    logic       done_r;
    logic       accept_s;

    function automatic logic frame_parity(input logic acc_val);
`ifdef PARITY_ODD_EN
        return ~acc_val;
`else
        return acc_val;
`endif
    endfunction

    // ready_r is high exactly while the FSM sits in ACCUM
    assign accept_s = bit_valid_in & ready_r;

    // Next-state, accumulator, counter and parity-capture logic
    always_comb begin
        state_nxt_s  = state_r;
        acc_nxt_s    = acc_r;
        count_nxt_s  = count_r;
        parity_nxt_s = parity_r;
        case (state_r)
            IDLE: begin
                if (start_in) begin
                    state_nxt_s = ACCUM;
                    acc_nxt_s   = 1'b0;
                    count_nxt_s = 9'd0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCUM: begin
                // Abort outranks a same-cycle accept; the bit is dropped
                if (abort_in) begin
                    state_nxt_s = IDLE;
                    acc_nxt_s   = 1'b0;
                    count_nxt_s = 9'd0;
                end else if (accept_s) begin
                    acc_nxt_s = acc_r ^ bit_in;
                    if (count_r < LAST_CNT) begin
                        count_nxt_s = count_r + 9'd1;
                    end else begin
                        count_nxt_s = count_r;
                    end
                    if ((count_r + 9'd1) >= LAST_CNT) begin
                        state_nxt_s  = DONE;
                        parity_nxt_s = frame_parity(acc_r ^ bit_in);
                    end else begin
                        state_nxt_s = ACCUM;
                    end
                end else begin
                    state_nxt_s = ACCUM;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
                acc_nxt_s   = 1'b0;
                count_nxt_s = 9'd0;
            end
        endcase
    end

    // State and registered outputs; status flags decode the next state so they line up with it
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r  <= IDLE;
            acc_r    <= 1'b0;
            count_r  <= 9'd0;
            parity_r <= 1'b0;
            ready_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            acc_r    <= acc_nxt_s;
            count_r  <= count_nxt_s;
            parity_r <= parity_nxt_s;
            ready_r  <= (state_nxt_s == ACCUM);
            busy_r   <= (state_nxt_s == ACCUM) || (state_nxt_s == DONE);
            done_r   <= (state_nxt_s == DONE);
        end
    end

    assign bit_ready_out = ready_r;
    assign busy_out      = busy_r;
    assign count_out     = count_r;
    assign parity_out    = parity_r;
    assign done_out      = done_r;

endmodule

// File: tb/tb_serial_parity_gen.sv
// Self-checking bench for serial_parity_gen: directed scenarios plus randomized frames against a bit-counting parity model.
module tb_serial_parity_gen;

    localparam int FL = 8;

    logic       clk_in;
    logic       rst_n_in;
    logic       start_in;
    logic       abort_in;
    logic       bit_in;
    logic       bit_valid_in;
    logic       bit_ready_out;
    logic       busy_out;
    logic [8:0] count_out;
    logic       parity_out;
    logic       done_out;

    int checks;
    int errors;
    int done_cnt;
    logic exp_parity;

    serial_parity_gen #(.FRAME_LEN(FL)) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .start_in      (start_in),
        .abort_in      (abort_in),
        .bit_in        (bit_in),
        .bit_valid_in  (bit_valid_in),
        .bit_ready_out (bit_ready_out),
        .busy_out      (busy_out),
        .count_out     (count_out),
        .parity_out    (parity_out),
        .done_out      (done_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Count done pulses, sampled mid-cycle
    always @(negedge clk_in) begin
        if (done_out === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #2;
    endtask

    // Reference: parity is the count of ones mod 2, inverted in the odd build
    function automatic logic model_parity(input logic [FL-1:0] bits);
        int ones;
        ones = 0;
        for (int k = 0; k < FL; k++) ones += int'(bits[k]);
`ifdef PARITY_ODD_EN
        return (ones % 2) == 0;
`else
        return (ones % 2) == 1;
`endif
    endfunction

    task automatic send_frame(input logic [FL-1:0] bits, input int gap, input int abort_idx, input logic noise);
        int d0;
        d0 = done_cnt;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        check("start_busy", busy_out, 1);
        check("start_ready", bit_ready_out, 1);
        check("start_count", count_out, 0);
        check("start_parity_held", parity_out, exp_parity);
        for (int i = 0; i < FL; i++) begin
            for (int g = 0; g < gap; g++) begin
                bit_valid_in = 1'b0;
                bit_in = $urandom_range(0, 1);
                start_in = noise;
                tick();
                start_in = 1'b0;
                check("gap_count", count_out, i);
                check("gap_ready", bit_ready_out, 1);
            end
            bit_valid_in = 1'b1;
            bit_in = bits[i];
            abort_in = (i == abort_idx);
            start_in = noise;
            tick();
            bit_valid_in = 1'b0;
            abort_in = 1'b0;
            start_in = 1'b0;
            if (i == abort_idx) begin
                check("abort_busy", busy_out, 0);
                check("abort_count", count_out, 0);
                check("abort_done", done_out, 0);
                check("abort_parity", parity_out, exp_parity);
                tick();
                check("abort_no_pulse", done_cnt, d0);
                return;
            end
            if (i < FL - 1) begin
                check("acc_count", count_out, i + 1);
                check("acc_done", done_out, 0);
            end
        end
        exp_parity = model_parity(bits);
        check("done_pulse", done_out, 1);
        check("done_parity", parity_out, exp_parity);
        check("done_count", count_out, FL);
        check("done_busy", busy_out, 1);
        check("done_ready", bit_ready_out, 0);
        start_in = noise;
        tick();
        start_in = 1'b0;
        check("post_done", done_out, 0);
        check("post_busy", busy_out, 0);
        check("post_count", count_out, FL);
        check("post_parity", parity_out, exp_parity);
        check("one_pulse", done_cnt, d0 + 1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        done_cnt = 0;
        exp_parity = 1'b0;
        rst_n_in = 1'b0;
        start_in = 1'b0;
        abort_in = 1'b0;
        bit_in = 1'b0;
        bit_valid_in = 1'b0;
        #12;
        check("rst_busy", busy_out, 0);
        check("rst_ready", bit_ready_out, 0);
        check("rst_count", count_out, 0);
        check("rst_parity", parity_out, 0);
        check("rst_done", done_out, 0);
        rst_n_in = 1'b1;
        tick();

        // Bits 1,0,1,1,0,0,0,0 back to back
        send_frame(8'b0000_1101, 0, -1, 1'b0);
        // All-zero frame
        send_frame(8'b0000_0000, 0, -1, 1'b0);
        // Gapped: one valid every 3 cycles, bits 1,1,1,0,...
        send_frame(8'b0000_0111, 2, -1, 1'b0);
        // Abort with the 5th bit
        send_frame(8'b1111_1111, 0, 4, 1'b0);
        // Start pulsed during ACCUM and DONE
        send_frame(8'b1010_0110, 1, -1, 1'b1);
        tick();
        check("noise_idle", busy_out, 0);

        // Abort alone in IDLE is ignored; abort with start counts as start
        abort_in = 1'b1;
        tick();
        check("idle_abort", busy_out, 0);
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        abort_in = 1'b0;
        check("abort_start", busy_out, 1);
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        check("abort_empty", busy_out, 0);

        // Ensure parity_out is 1 before the reset test in either build
        send_frame(8'b0000_0001, 0, -1, 1'b0);
        if (exp_parity == 1'b0) send_frame(8'b0000_0000, 0, -1, 1'b0);

        // Reset between edges after 3 accepted bits
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        bit_valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bit_in = 1'b1;
            tick();
        end
        bit_valid_in = 1'b0;
        check("pre_rst_count", count_out, 3);
        rst_n_in = 1'b0;
        #1;
        check("mid_rst_busy", busy_out, 0);
        check("mid_rst_ready", bit_ready_out, 0);
        check("mid_rst_count", count_out, 0);
        check("mid_rst_parity", parity_out, 0);
        check("mid_rst_done", done_out, 0);
        #1;
        rst_n_in = 1'b1;
        exp_parity = 1'b0;
        send_frame(8'b0110_1011, 0, -1, 1'b0);

        // Randomized frames
        for (int n = 0; n < 30; n++) begin
            logic [FL-1:0] rb;
            int ab;
            rb = FL'($urandom);
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, FL - 1)) : -1;
            send_frame(rb, int'($urandom_range(0, 2)), ab, 1'($urandom_range(0, 1)));
            for (int w = 0; w < int'($urandom_range(0, 2)); w++) begin
                tick();
                check("rand_idle", busy_out, 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_parity_gen.md
SERIAL_PARITY_GEN -- requirements
Module: serial_parity_gen

Interface
REQ-001 The block SHALL have one parameter: FRAME_LEN, default 8, number of bits per frame (legal range 2..256).
REQ-002 The block SHALL have port clk_in, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port rst_n_in, input, 1, reset; asynchronous and active-low.
REQ-004 The block SHALL have port start_in, input, 1, begins a frame when sampled high in IDLE.
REQ-005 The block SHALL have port abort_in, input, 1, cancels the current frame.
REQ-006 The block SHALL have port bit_in, input, 1, serial data bit.
REQ-007 The block SHALL have port bit_valid_in, input, 1, bit_in is valid this cycle.
REQ-008 The block SHALL have port bit_ready_out, output, 1, the block accepts a bit this cycle.
REQ-009 The block SHALL have port busy_out, output, 1, high in ACCUM and DONE.
REQ-010 The block SHALL have port count_out, output, 9, number of bits accepted in the current frame.
REQ-011 The block SHALL have port parity_out, output, 1, parity of the last completed frame.
REQ-012 The block SHALL have port done_out, output, 1, one-cycle pulse marking a completed frame.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, ACCUM, DONE.
REQ-014 In IDLE with start_in=1, the block SHALL do the following on the next edge: go to ACCUM, clear acc and count_out; parity_out SHALL be held.
REQ-015 The block SHALL drive bit_ready_out=1 only in ACCUM; a bit is accepted when bit_valid_in and bit_ready_out are both 1.
REQ-016 On each accept, the block SHALL update acc <= acc XOR bit_in and increment count_out by 1.
REQ-017 Cycles with bit_valid_in=0 SHALL leave acc and count_out unchanged; gaps of any length are allowed.
REQ-018 When the accepted bit is the FRAME_LEN-th, the next state SHALL be DONE, and parity_out SHALL be loaded with the final parity on that same edge.
REQ-019 In DONE, done_out SHALL be 1 for exactly one cycle, and the state SHALL return to IDLE unconditionally.
REQ-020 Latency from the final accepted bit to done_out SHALL be 1 cycle.
REQ-021 parity_out SHALL hold its value until the next frame completes; abort and start SHALL NOT alter it.
REQ-022 start_in SHALL be ignored in ACCUM and DONE.
REQ-023 abort_in=1 in ACCUM SHALL return the FSM to IDLE on the next edge, with no done_out pulse and count_out cleared.
REQ-024 When abort_in and an accept occur in the same cycle, abort SHALL win and the bit SHALL be discarded.
REQ-025 abort_in SHALL be ignored in IDLE and DONE.
REQ-026 When abort_in and start_in are both high in IDLE, the block SHALL treat the cycle as a start.
REQ-027 count_out SHALL saturate at FRAME_LEN and never wrap; it SHALL be cleared on entry to ACCUM and on abort, and held through DONE/IDLE after completion.

Reset
REQ-028 rst_n_in low SHALL immediately force state=IDLE, acc=0, count_out=0, parity_out=0, done_out=0, bit_ready_out=0, busy_out=0, independent of clk_in.
REQ-029 Reset asserted mid-frame SHALL discard the frame with no done_out pulse.
REQ-030 The first start SHALL be accepted on the first rising edge after rst_n_in deasserts.

Configuration
REQ-031 The block SHALL recognise exactly one compile-time macro, PARITY_ODD_EN.
REQ-032 With PARITY_ODD_EN defined, the completed-frame value loaded into parity_out SHALL be NOT acc (odd parity).
REQ-033 With PARITY_ODD_EN undefined, the loaded value SHALL be acc (even parity).
REQ-034 The reset value of parity_out SHALL be 0 in both builds.

Verification
REQ-035 The bench SHALL cover this scenario: FRAME_LEN=8, macro off; start, then bits 1,0,1,1,0,0,0,0 on consecutive cycles -> done_out pulse 1 cycle after the 8th accept, parity_out=1, count_out=8.
REQ-036 The bench SHALL cover this scenario: same stimulus with PARITY_ODD_EN -> parity_out=0; all-zero frame -> parity_out=1.
REQ-037 The bench SHALL cover this scenario: bit_valid_in gapped (1 valid every 3 cycles), bits 1,1,1,0,0,0,0,0 -> parity_out=1 (even build), with exactly one done_out pulse.
REQ-038 The bench SHALL cover this scenario: abort_in together with the 5th bit -> IDLE next cycle, count_out=0, no done_out, parity_out unchanged from the prior frame.
REQ-039 The bench SHALL cover this scenario: rst_n_in low between clock edges after 3 bits -> all outputs 0 immediately; a fresh frame after release completes normally.
REQ-040 The bench SHALL cover this scenario: start_in pulsed during ACCUM and in the DONE cycle -> ignored; count_out continues, and the FSM goes to IDLE after DONE.
